// File: rtl/e_x_pkg.sv
// Shared constants for the e^x range-reduction pre/post-processing blocks.
package e_x_pkg;

  localparam int          MANT_FRAC  = 30;                  // e^r mantissa is Q2.30
  localparam int          Y_FRAC     = 16;                  // result is Q16.16
  localparam int          SHIFT_BIAS = MANT_FRAC - Y_FRAC;  // 14: Q2.30 -> Q16.16 alignment
  localparam logic [31:0] Y_MAX      = 32'hFFFF_FFFF;

  typedef logic [31:0] mant_t;
  typedef logic [31:0] y_t;

endpackage

// File: rtl/e_x_shift_round.sv
// Combinational scale-by-2^sh of a Q2.30 mantissa into an unsigned Q16.16
// result: left shifts saturate on overflow, right shifts round half up.
module e_x_shift_round
  import e_x_pkg::*;
#(
  parameter int SH_W = 9
) (
  input  mant_t                  mant_i,
  input  logic signed [SH_W-1:0] sh_i,
  output y_t                     y_o,
  output logic                   sat_o
);

  logic            neg;
  logic [SH_W-1:0] mag;
  logic [63:0]     field;

  // Barrel shift into a 64-bit field, then clamp (left) or round (right).
  always_comb begin
    neg   = sh_i[SH_W-1];
    mag   = neg ? SH_W'(-sh_i) : SH_W'(sh_i);
    field = '0;
    y_o   = '0;
    sat_o = 1'b0;
    if (mant_i == '0) begin
      y_o = '0;
    end else if (!neg) begin
      if (mag >= SH_W'(32)) begin
        y_o   = Y_MAX;
        sat_o = 1'b1;
      end else begin
        field = {32'd0, mant_i} << mag[4:0];
        if (|field[63:32]) begin
          y_o   = Y_MAX;
          sat_o = 1'b1;
        end else begin
          y_o = field[31:0];
        end
      end
    end else if (mag <= SH_W'(32)) begin
      // Upper half is the truncated quotient, bit 31 is the first dropped bit.
      // Truncated value is at most 0x7FFFFFFF here, so the +1 cannot wrap.
      field = {mant_i, 32'd0} >> mag[5:0];
      y_o   = field[63:32] + {31'd0, field[31]};
    end
  end

endmodule

// File: rtl/e_x_postprocess.sv
// e^x = 2^k * e^r reconstruction: 3-stage valid/ready pipeline that scales the
// Q2.30 e^r mantissa by 2^k into a saturated, rounded Q16.16 result and keeps a
// sticky count of saturated outputs. rst_n is asserted asynchronously and is
// expected to be released synchronously to clk by the reset source.
module e_x_postprocess
  import e_x_pkg::*;
#(
  parameter int K_W   = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [K_W-1:0] in_k,
  input  logic [31:0]           in_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_y,
  output logic                  out_sat,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      sat_count
);

  localparam int SH_W = K_W + 1;

  logic                   vld_p1_q, vld_p2_q, vld_p3_q;
  logic                   ld_p1, ld_p2, ld_p3;
  logic signed [K_W-1:0]  k_p1_q;
  mant_t                  mant_p1_q, mant_p2_q;
  logic signed [SH_W-1:0] sh_p2_d, sh_p2_q;
  y_t                     y_p3_d, y_p3_q;
  logic                   sat_p3_d, sat_p3_q;
  logic                   out_fire;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  // A stage loads when it is empty or its downstream neighbour is loading,
  // so bubbles collapse and a full pipe still streams one item per cycle.
  assign ld_p3    = !vld_p3_q || out_ready;
  assign ld_p2    = !vld_p2_q || ld_p3;
  assign ld_p1    = !vld_p1_q || ld_p2;
  assign in_ready = ld_p1;

  // Stage valid bits move with their stage loads; reset empties the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (ld_p1) vld_p1_q <= in_valid;
      if (ld_p2) vld_p2_q <= vld_p1_q;
      if (ld_p3) vld_p3_q <= vld_p2_q;
    end
  end

  // ---- Stage 1: capture exponent and mantissa.
  always_ff @(posedge clk) begin
    if (ld_p1 && in_valid) begin
      k_p1_q    <= in_k;
      mant_p1_q <= in_mant;
    end
  end

  // ---- Stage 2: net shift combines 2^k with the Q2.30 -> Q16.16 realignment.
  assign sh_p2_d = $signed({k_p1_q[K_W-1], k_p1_q}) - $signed(SH_W'(SHIFT_BIAS));

  // Register the shift amount alongside its mantissa.
  always_ff @(posedge clk) begin
    if (ld_p2 && vld_p1_q) begin
      sh_p2_q   <= sh_p2_d;
      mant_p2_q <= mant_p1_q;
    end
  end

  e_x_shift_round #(
    .SH_W (SH_W)
  ) u_shift_round (
    .mant_i (mant_p2_q),
    .sh_i   (sh_p2_q),
    .y_o    (y_p3_d),
    .sat_o  (sat_p3_d)
  );

  // ---- Stage 3: result register; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p3_q   <= '0;
      sat_p3_q <= 1'b0;
    end else if (ld_p3 && vld_p2_q) begin
      y_p3_q   <= y_p3_d;
      sat_p3_q <= sat_p3_d;
    end
  end

  assign out_valid = vld_p3_q;
  assign out_y     = y_p3_q;
  assign out_sat   = sat_p3_q;
  assign out_fire  = vld_p3_q && out_ready;

  // Saturating count of delivered clamped results; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_fire && sat_p3_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;

endmodule
